lsu_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the load-store unit. Requester 0 is the core data port; requester 1 is the secondary master (debug/loader). The block applies round-robin arbitration and drives the LSU with exactly one access per transaction. It parks the LSU bus on a harmless address when idle, because the LSU writes its IO registers on an address match regardless of `st_en`. It also services IO loads directly, because the LSU cannot return IO values.

---
 rtl/lsu_arbiter.sv | 147 ++++++++++++++
 tb/tb_lsu_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_arbiter.sv
// rtl/lsu_arbiter.sv - two-port round-robin arbiter and sequencer in front of the LSU
module lsu_arbiter #(
    parameter logic [31:0] PARK_ADDR = 32'h0000_0000,
    parameter logic [31:0] IO_LO     = 32'h0000_0800,
    parameter logic [31:0] IO_HI     = 32'h0000_08FF,
    parameter logic [31:0] SW_ADDR   = 32'h0000_09FF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        r0_req_i,
    input  logic        r0_we_i,
    input  logic [31:0] r0_addr_i,
    input  logic [31:0] r0_wdata_i,
    input  logic        r1_req_i,
    input  logic        r1_we_i,
    input  logic [31:0] r1_addr_i,
    input  logic [31:0] r1_wdata_i,
    output logic        r0_gnt_o,
    output logic        r1_gnt_o,
    output logic        r0_rvalid_o,
    output logic        r1_rvalid_o,
    output logic [31:0] r0_rdata_o,
    output logic [31:0] r1_rdata_o,
    output logic [31:0] lsu_addr_o,
    output logic [31:0] lsu_st_data_o,
    output logic        lsu_st_en_o,
    input  logic [31:0] lsu_ld_data_i,
    input  logic [31:0] io_sw_i,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {CLS_NORMAL, CLS_ZERO, CLS_SW} cls_t;

    state_t      state_q, state_d;
    logic        last_q;
    logic        id_q, we_q;
    cls_t        cls_q;
    logic        rvalid0_q, rvalid1_q;
    logic [31:0] lsu_addr_q, lsu_st_data_q;
    logic        lsu_st_en_q, busy_q;

    logic        grant, win_id, win_we;
    logic [31:0] win_addr, win_wdata;
    cls_t        win_cls;
    logic [31:0] lsu_addr_d, lsu_st_data_d, resp_data;
    logic        lsu_st_en_d;

    // Arbitration: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        if (r0_req_i && r1_req_i) begin
            win_id = ~last_q;
        end else begin
            win_id = r1_req_i;
        end
        win_we    = win_id ? r1_we_i    : r0_we_i;
        win_addr  = win_id ? r1_addr_i  : r0_addr_i;
        win_wdata = win_id ? r1_wdata_i : r0_wdata_i;
        if (win_addr == SW_ADDR) begin
            win_cls = CLS_SW;
        end else if (!win_we && win_addr >= IO_LO && win_addr <= IO_HI) begin
            win_cls = CLS_ZERO;
        end else begin
            win_cls = CLS_NORMAL;
        end
        grant = rst_ni && (state_q == IDLE) && (r0_req_i || r1_req_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The LSU bus is loaded at the grant edge so the access is on the bus in ACCESS.
    always_comb begin
        r0_gnt_o      = grant && !win_id;
        r1_gnt_o      = grant && win_id;
        lsu_addr_d    = PARK_ADDR;
        lsu_st_data_d = 32'h0;
        lsu_st_en_d   = 1'b0;
        if (grant && win_cls == CLS_NORMAL) begin
            lsu_addr_d    = win_addr;
            lsu_st_data_d = win_wdata;
            lsu_st_en_d   = win_we;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q        <= 1'b1;
            id_q          <= 1'b0;
            we_q          <= 1'b0;
            cls_q         <= CLS_NORMAL;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
            lsu_addr_q    <= PARK_ADDR;
            lsu_st_data_q <= 32'h0;
            lsu_st_en_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            if (grant) begin
                last_q <= win_id;
                id_q   <= win_id;
                we_q   <= win_we;
                cls_q  <= win_cls;
            end
            rvalid0_q     <= (state_q == ACCESS) && !id_q;
            rvalid1_q     <= (state_q == ACCESS) && id_q;
            lsu_addr_q    <= lsu_addr_d;
            lsu_st_data_q <= lsu_st_data_d;
            lsu_st_en_q   <= lsu_st_en_d;
            busy_q        <= (state_d != IDLE);
        end
    end

    // Load data is steered from registered selects; LSU and switch data are valid in RESP.
    always_comb begin
        if (we_q || cls_q == CLS_ZERO) begin
            resp_data = 32'h0;
        end else if (cls_q == CLS_SW) begin
            resp_data = io_sw_i;
        end else begin
            resp_data = lsu_ld_data_i;
        end
    end

    assign r0_rvalid_o   = rvalid0_q;
    assign r1_rvalid_o   = rvalid1_q;
    assign r0_rdata_o    = rvalid0_q ? resp_data : 32'h0;
    assign r1_rdata_o    = rvalid1_q ? resp_data : 32'h0;
    assign lsu_addr_o    = lsu_addr_q;
    assign lsu_st_data_o = lsu_st_data_q;
    assign lsu_st_en_o   = lsu_st_en_q;
    assign busy_o        = busy_q;
endmodule

// File: tb/tb_lsu_arbiter.sv
// tb/tb_lsu_arbiter.sv - self-checking bench for lsu_arbiter
module tb_lsu_arbiter;
    localparam logic [31:0] PARK  = 32'h0000_0000;
    localparam logic [31:0] IO_LO = 32'h0000_0800;
    localparam logic [31:0] IO_HI = 32'h0000_08FF;
    localparam logic [31:0] SW    = 32'h0000_09FF;
    localparam int NR = 600;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic [31:0] lsu_addr, lsu_st_data, lsu_ld_data, io_sw;
    logic        lsu_st_en, busy;

    always #5 clk = ~clk;

    lsu_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .r0_req_i(r0_req), .r0_we_i(r0_we), .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata),
        .r1_req_i(r1_req), .r1_we_i(r1_we), .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata),
        .r0_gnt_o(r0_gnt), .r1_gnt_o(r1_gnt),
        .r0_rvalid_o(r0_rvalid), .r1_rvalid_o(r1_rvalid),
        .r0_rdata_o(r0_rdata), .r1_rdata_o(r1_rdata),
        .lsu_addr_o(lsu_addr), .lsu_st_data_o(lsu_st_data), .lsu_st_en_o(lsu_st_en),
        .lsu_ld_data_i(lsu_ld_data), .io_sw_i(io_sw), .busy_o(busy)
    );

    function automatic logic [31:0] ldfn(logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clk) lsu_ld_data <= ldfn(lsu_addr);

    // Reference rules: which accesses reach the LSU and what a completion returns.
    function automatic bit on_bus(logic we, logic [31:0] a);
        return !(a == SW) && !(!we && a >= IO_LO && a <= IO_HI);
    endfunction

    function automatic logic [31:0] ref_rdata(logic we, logic [31:0] a, logic [31:0] sw);
        if (we) return 32'h0;
        if (a == SW) return sw;
        if (a >= IO_LO && a <= IO_HI) return 32'h0;
        return ldfn(a);
    endfunction

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(int p, logic req, logic we, logic [31:0] a, logic [31:0] wd);
        if (p == 0) begin
            r0_req = req; r0_we = we; r0_addr = a; r0_wdata = wd;
        end else begin
            r1_req = req; r1_we = we; r1_addr = a; r1_wdata = wd;
        end
    endtask

    task automatic chk_reset_vals(string nm);
        chk({nm, " gnt0"}, r0_gnt, 0);
        chk({nm, " gnt1"}, r1_gnt, 0);
        chk({nm, " rvalid0"}, r0_rvalid, 0);
        chk({nm, " rvalid1"}, r1_rvalid, 0);
        chk({nm, " rdata0"}, r0_rdata, 0);
        chk({nm, " rdata1"}, r1_rdata, 0);
        chk({nm, " lsu_addr"}, lsu_addr, PARK);
        chk({nm, " st_data"}, lsu_st_data, 0);
        chk({nm, " st_en"}, lsu_st_en, 0);
        chk({nm, " busy"}, busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 1, 0, 32'h40, 0);
        drive(1, 1, 0, 32'h44, 0);
        @(negedge clk);
        #1;
        chk_reset_vals("reset");
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] sw;
        logic [31:0] e_addr;
        logic [31:0] e_sd;
        logic        e_en;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vt[10];

    task automatic single(vec_t v);
        int p;
        p = v.port;
        @(negedge clk);
        io_sw = v.sw;
        drive(p, 1, v.we, v.addr, v.wdata);
        #1;
        chk("vec gnt", p ? r1_gnt : r0_gnt, 1);
        chk("vec gnt other", p ? r0_gnt : r1_gnt, 0);
        @(posedge clk);
        #1 drive(p, 0, 0, 0, 0);
        @(negedge clk);
        chk("vec lsu_addr", lsu_addr, v.e_addr);
        chk("vec st_data", lsu_st_data, v.e_sd);
        chk("vec st_en", lsu_st_en, v.e_en);
        chk("vec busy access", busy, 1);
        chk("vec early rvalid", p ? r1_rvalid : r0_rvalid, 0);
        @(negedge clk);
        chk("vec rvalid", p ? r1_rvalid : r0_rvalid, 1);
        chk("vec rvalid other", p ? r0_rvalid : r1_rvalid, 0);
        chk("vec rdata", p ? r1_rdata : r0_rdata, v.e_rd);
        chk("vec rdata other", p ? r0_rdata : r1_rdata, 0);
        chk("vec park resp", lsu_addr, PARK);
        chk("vec st_en resp", lsu_st_en, 0);
        @(negedge clk);
        chk("vec rvalid after", p ? r1_rvalid : r0_rvalid, 0);
        chk("vec busy idle", busy, 0);
    endtask

    // Random-run expectations indexed by cycle number.
    logic [31:0] e_addr[NR+3];
    logic [31:0] e_sd[NR+3];
    logic        e_en[NR+3];
    logic        e_busy[NR+3];
    int          e_rv[NR+3];
    logic        e_rwe[NR+3];
    logic [31:0] e_raddr[NR+3];

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        io_sw = 32'h0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        do_reset();

        vt[0] = '{0, 1'b0, 32'h10,   32'h0,    32'h0,   32'h10,   32'h0,    1'b0, 32'hDEAD_BEEF};
        vt[1] = '{1, 1'b1, 32'h820,  32'h5A,   32'h0,   32'h820,  32'h5A,   1'b1, 32'h0};
        vt[2] = '{0, 1'b0, 32'h830,  32'h0,    32'h0,   PARK,     32'h0,    1'b0, 32'h0};
        vt[3] = '{0, 1'b0, 32'h9FF,  32'h0,    32'h3C5, PARK,     32'h0,    1'b0, 32'h3C5};
        vt[4] = '{0, 1'b1, 32'h9FF,  32'h77,   32'h3C5, PARK,     32'h0,    1'b0, 32'h0};
        vt[5] = '{1, 1'b0, 32'h900,  32'h0,    32'h0,   32'h900,  32'h0,    1'b0, 32'h0900_F6FF};
        vt[6] = '{0, 1'b0, 32'h8FF,  32'h0,    32'h0,   PARK,     32'h0,    1'b0, 32'h0};
        vt[7] = '{1, 1'b0, 32'h800,  32'h0,    32'h0,   PARK,     32'h0,    1'b0, 32'h0};
        vt[8] = '{0, 1'b0, 32'h7FC,  32'h1234, 32'h0,   32'h7FC,  32'h1234, 1'b0, 32'h07FC_F803};
        vt[9] = '{1, 1'b1, 32'h1000, 32'hCAFE, 32'h0,   32'h1000, 32'hCAFE, 1'b1, 32'h0};
        for (int i = 0; i < 10; i++) single(vt[i]);

        // Tie from reset: r0, r1, r0, r1 every three cycles.
        do_reset();
        @(negedge clk);
        drive(0, 1, 0, 32'h100, 0);
        drive(1, 1, 0, 32'h104, 0);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            chk("tie rvalid0", r0_rvalid, (k % 6 == 2) ? 1 : 0);
            chk("tie rvalid1", r1_rvalid, (k % 6 == 5) ? 1 : 0);
            #1;
            chk("tie gnt0", r0_gnt, (k % 6 == 0) ? 1 : 0);
            chk("tie gnt1", r1_gnt, (k % 6 == 3) ? 1 : 0);
        end
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        // Reset during the ACCESS cycle of an r1 load.
        do_reset();
        @(negedge clk);
        drive(1, 1, 0, 32'h40, 0);
        #1 chk("midrst gnt1", r1_gnt, 1);
        @(posedge clk);
        #1 drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("midrst lsu_addr", lsu_addr, 32'h40);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst no rvalid1", r1_rvalid, 0);
            chk("midrst busy", busy, 0);
        end
        drive(0, 1, 0, 32'h50, 0);
        drive(1, 1, 0, 32'h54, 0);
        #1;
        chk("midrst tie gnt0", r0_gnt, 1);
        chk("midrst tie gnt1", r1_gnt, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        // r1 request raised in r0's RESP and withdrawn before IDLE.
        @(negedge clk);
        drive(0, 1, 0, 32'h20, 0);
        #1 chk("wd gnt0", r0_gnt, 1);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("wd resp rvalid0", r0_rvalid, 1);
        drive(1, 1, 0, 32'h24, 0);
        #1 chk("wd gnt1 in resp", r1_gnt, 0);
        #1 drive(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("wd gnt1", r1_gnt, 0);
            chk("wd busy", busy, 0);
            chk("wd rvalid1", r1_rvalid, 0);
        end

        // Random traffic against a cycle-indexed transaction model.
        do_reset();
        begin
            bit          pend[2];
            logic        pwe[2];
            logic [31:0] paddr[2], pwd[2];
            int          free_c, w, sel;
            bit          last, g0, g1;
            logic [31:0] a;
            pend[0] = 0; pend[1] = 0;
            free_c = 0; last = 1;
            for (int i = 0; i < NR + 3; i++) begin
                e_addr[i] = PARK; e_sd[i] = 0; e_en[i] = 0; e_busy[i] = 0;
                e_rv[i] = 0; e_rwe[i] = 0; e_raddr[i] = 0;
            end
            for (int c = 0; c < NR; c++) begin
                @(negedge clk);
                chk("rnd lsu_addr", lsu_addr, e_addr[c]);
                chk("rnd st_data", lsu_st_data, e_sd[c]);
                chk("rnd st_en", lsu_st_en, e_en[c]);
                chk("rnd busy", busy, e_busy[c]);
                chk("rnd rvalid0", r0_rvalid, (e_rv[c] == 1) ? 1 : 0);
                chk("rnd rvalid1", r1_rvalid, (e_rv[c] == 2) ? 1 : 0);
                chk("rnd rdata0", r0_rdata,
                    (e_rv[c] == 1) ? ref_rdata(e_rwe[c], e_raddr[c], io_sw) : 32'h0);
                chk("rnd rdata1", r1_rdata,
                    (e_rv[c] == 2) ? ref_rdata(e_rwe[c], e_raddr[c], io_sw) : 32'h0);
                io_sw = $urandom;
                for (int p = 0; p < 2; p++) begin
                    if (!pend[p] && $urandom_range(0, 2) == 0) begin
                        sel = $urandom_range(0, 5);
                        case (sel)
                            0: a = 32'h1000 + 4 * $urandom_range(0, 255);
                            1: a = IO_LO + $urandom_range(0, 255);
                            2: a = SW;
                            3: a = IO_LO - 1;
                            4: a = IO_HI + 1;
                            default: a = ($urandom_range(0, 1) == 1) ? IO_LO : IO_HI;
                        endcase
                        pend[p] = 1; pwe[p] = $urandom_range(0, 1) == 1;
                        paddr[p] = a; pwd[p] = $urandom;
                    end
                    drive(p, pend[p], pend[p] ? pwe[p] : 1'b0,
                          pend[p] ? paddr[p] : 32'h0, pend[p] ? pwd[p] : 32'h0);
                end
                g0 = 0; g1 = 0;
                if (c >= free_c && (pend[0] || pend[1])) begin
                    w = (pend[0] && pend[1]) ? (last ? 0 : 1) : (pend[1] ? 1 : 0);
                    last = (w == 1);
                    if (w == 0) g0 = 1; else g1 = 1;
                    if (on_bus(pwe[w], paddr[w])) begin
                        e_addr[c+1] = paddr[w]; e_sd[c+1] = pwd[w]; e_en[c+1] = pwe[w];
                    end
                    e_busy[c+1] = 1; e_busy[c+2] = 1;
                    e_rv[c+2] = w + 1; e_rwe[c+2] = pwe[w]; e_raddr[c+2] = paddr[w];
                    free_c = c + 3;
                    pend[w] = 0;
                end
                #1;
                chk("rnd gnt0", r0_gnt, g0);
                chk("rnd gnt1", r1_gnt, g1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
